// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands MSB first, DIGIT bits per
// cycle, stopping at the first differing digit. Optional counters: SERIAL_MAGNITUDE_COMPARATOR_STATS_EN.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          signed_mode,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
`ifdef SERIAL_MAGNITUDE_COMPARATOR_STATS_EN
  input  logic                          stats_clr,
  output logic [CNT_W-1:0]              cnt_a_big,
  output logic [CNT_W-1:0]              cnt_b_big,
  output logic [CNT_W-1:0]              cnt_equal,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          a_big,
  output logic                          b_big,
  output logic                          equal,
  output logic [$clog2(WIDTH/DIGIT):0]  steps
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned SW   = $clog2(NDIG) + 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || CNT_W < 1) begin : g_param_check
    $error("serial_magnitude_comparator: illegal WIDTH/DIGIT/CNT_W combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_sa;
  logic [WIDTH-1:0]  r_sb;
  logic [SW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_a_big;
  logic              r_b_big;
  logic              r_equal;
  logic [SW-1:0]     r_steps;

  logic [DIGIT-1:0]  w_digit_a;
  logic [DIGIT-1:0]  w_digit_b;
  logic              w_digit_ne;
  logic              w_last;
  logic              w_load;
  logic              w_finish;
  logic              w_shift;
  logic [WIDTH-1:0]  w_sign_mask;

  assign w_digit_a   = r_sa[WIDTH-1 -: DIGIT];
  assign w_digit_b   = r_sb[WIDTH-1 -: DIGIT];
  assign w_digit_ne  = (w_digit_a != w_digit_b);
  assign w_last      = (r_cnt == SW'(NDIG));
  // Flipping both sign bits maps two's complement onto offset binary, so the unsigned walk stays valid.
  assign w_sign_mask = signed_mode ? MSB_MASK : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_digit_ne || w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load   = 1'b0;
    w_finish = 1'b0;
    w_shift  = 1'b0;
    case (r_state)
      S_IDLE:  w_load = start;
      S_RUN: begin
        w_finish = w_digit_ne || w_last;
        w_shift  = !(w_digit_ne || w_last);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_a_big <= 1'b0;
      r_b_big <= 1'b0;
      r_equal <= 1'b0;
      r_steps <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_finish;
      if (w_load) begin
        r_sa  <= a ^ w_sign_mask;
        r_sb  <= b ^ w_sign_mask;
        r_cnt <= SW'(1);
      end else if (w_shift) begin
        r_sa  <= r_sa << DIGIT;
        r_sb  <= r_sb << DIGIT;
        r_cnt <= r_cnt + SW'(1);
      end
      if (w_finish) begin
        r_a_big <= w_digit_ne && (w_digit_a > w_digit_b);
        r_b_big <= w_digit_ne && (w_digit_b > w_digit_a);
        r_equal <= !w_digit_ne;
        r_steps <= r_cnt;
      end
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign a_big = r_a_big;
  assign b_big = r_b_big;
  assign equal = r_equal;
  assign steps = r_steps;

`ifdef SERIAL_MAGNITUDE_COMPARATOR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt_a_big;
  logic [CNT_W-1:0] r_cnt_b_big;
  logic [CNT_W-1:0] r_cnt_equal;

  // Result registers are stable during the done cycle, so they select which counter to bump.
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      r_cnt_a_big <= '0;
      r_cnt_b_big <= '0;
      r_cnt_equal <= '0;
    end else if (r_done) begin
      if (r_a_big && r_cnt_a_big != CNT_MAX) r_cnt_a_big <= r_cnt_a_big + CNT_W'(1);
      if (r_b_big && r_cnt_b_big != CNT_MAX) r_cnt_b_big <= r_cnt_b_big + CNT_W'(1);
      if (r_equal && r_cnt_equal != CNT_MAX) r_cnt_equal <= r_cnt_equal + CNT_W'(1);
    end
  end

  assign cnt_a_big = r_cnt_a_big;
  assign cnt_b_big = r_cnt_b_big;
  assign cnt_equal = r_cnt_equal;
`endif

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator: directed scenarios plus randomized
// compares against an arithmetic reference model.
module tb_serial_magnitude_comparator;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIGIT = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned SW    = $clog2(NDIG) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_big;
  logic             b_big;
  logic             equal;
  logic [SW-1:0]    steps;
`ifdef SERIAL_MAGNITUDE_COMPARATOR_STATS_EN
  logic             stats_clr;
  logic [CNT_W-1:0] cnt_a_big;
  logic [CNT_W-1:0] cnt_b_big;
  logic [CNT_W-1:0] cnt_equal;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
`ifdef SERIAL_MAGNITUDE_COMPARATOR_STATS_EN
    .stats_clr   (stats_clr),
    .cnt_a_big   (cnt_a_big),
    .cnt_b_big   (cnt_b_big),
    .cnt_equal   (cnt_equal),
`endif
    .busy        (busy),
    .done        (done),
    .a_big       (a_big),
    .b_big       (b_big),
    .equal       (equal),
    .steps       (steps)
  );

  // Reference: integer compare for the verdict; steps = index of the first nonzero digit of a^b.
  function automatic logic [SW+2:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                          input logic sm);
    int ia;
    int ib;
    int dv;
    int st;
    if (sm) begin
      ia = int'($signed(ma));
      ib = int'($signed(mb));
    end else begin
      ia = int'(ma);
      ib = int'(mb);
    end
    dv = int'(ma ^ mb);
    st = NDIG;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (((dv >> (WIDTH - DIGIT * (i + 1))) % (1 << DIGIT)) != 0) st = i + 1;
    end
    return {ia > ib, ib > ia, ia == ib, SW'(st)};
  endfunction

  // Waits for IDLE, issues one start, returns edges until done (-1 on timeout).
  task automatic do_compare(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                            input logic tsm, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    a = ta;
    b = tb_v;
    signed_mode = tsm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    signed_mode = 1'b1;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, a_big, b_big, equal, steps} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 0", {busy, done, a_big, b_big, equal, steps});
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, a_big, b_big, equal, steps} !== '0) begin
      miscompares++;
      $display("FAIL idle_before_first_done: got %b required 0", {busy, done, a_big, b_big, equal, steps});
    end
  endtask

  task automatic test_early_exit();
    int lat;
    do_compare(8'hC3, 8'h13, 1'b0, lat);
    vectors++;
    if (lat !== 1 || {a_big, b_big, equal, steps} !== {3'b100, SW'(1)}) begin
      miscompares++;
      $display("FAIL early_exit_C3_13: lat=%0d res=%b required lat=1 res=%b", lat,
               {a_big, b_big, equal, steps}, {3'b100, SW'(1)});
    end
    do_compare(8'h5A, 8'h5B, 1'b0, lat);
    vectors++;
    if (lat !== 4 || {a_big, b_big, equal, steps} !== {3'b010, SW'(4)}) begin
      miscompares++;
      $display("FAIL last_digit_5A_5B: lat=%0d res=%b required lat=4 res=%b", lat,
               {a_big, b_big, equal, steps}, {3'b010, SW'(4)});
    end
  endtask

  task automatic test_equal();
    int lat;
    do_compare(8'h5A, 8'h5A, 1'b0, lat);
    vectors++;
    if (lat !== 4 || {a_big, b_big, equal, steps} !== {3'b001, SW'(4)}) begin
      miscompares++;
      $display("FAIL equal_5A: lat=%0d res=%b required lat=4 res=%b", lat,
               {a_big, b_big, equal, steps}, {3'b001, SW'(4)});
    end
  endtask

  task automatic test_signed();
    int lat;
    do_compare(8'hFF, 8'h01, 1'b1, lat);
    vectors++;
    if (lat !== 1 || {a_big, b_big, equal, steps} !== {3'b010, SW'(1)}) begin
      miscompares++;
      $display("FAIL signed_FF_01: lat=%0d res=%b required lat=1 res=%b", lat,
               {a_big, b_big, equal, steps}, {3'b010, SW'(1)});
    end
    do_compare(8'hFF, 8'h01, 1'b0, lat);
    vectors++;
    if (lat !== 1 || {a_big, b_big, equal, steps} !== {3'b100, SW'(1)}) begin
      miscompares++;
      $display("FAIL unsigned_FF_01: lat=%0d res=%b required lat=1 res=%b", lat,
               {a_big, b_big, equal, steps}, {3'b100, SW'(1)});
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_compare(8'h5A, 8'h5A, 1'b0, lat);
    vectors++;
    if (lat !== 4 || equal !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: lat=%0d equal=%b required lat=4 equal=1", lat, equal);
    end
    // Start held from the done cycle: ignored in DONE, taken on the following IDLE edge.
    a = 8'hC3;
    b = 8'h13;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, a_big, b_big, equal} !== 5'b00001) begin
      miscompares++;
      $display("FAIL b2b_idle_gap: got %b required 00001", {busy, done, a_big, b_big, equal});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b required 1", busy);
    end
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    vectors++;
    if (lat !== 1 || {a_big, b_big, equal, steps} !== {3'b100, SW'(1)}) begin
      miscompares++;
      $display("FAIL b2b_second: lat=%0d res=%b required lat=1 res=%b", lat,
               {a_big, b_big, equal, steps}, {3'b100, SW'(1)});
    end
  endtask

  task automatic test_robust();
    int lat;
    bit saw_done;
    @(negedge clk);
    while (busy) @(negedge clk);
    a = 8'h5A;
    b = 8'h5B;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    a = 8'hFF;
    b = 8'h00;
    signed_mode = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 2;
    while (lat < 20 && !done) begin
      @(posedge clk);
      #1;
      lat++;
    end
    vectors++;
    if (lat !== 4 || {a_big, b_big, equal, steps} !== {3'b010, SW'(4)}) begin
      miscompares++;
      $display("FAIL start_while_busy: lat=%0d res=%b required lat=4 res=%b", lat,
               {a_big, b_big, equal, steps}, {3'b010, SW'(4)});
    end
    @(negedge clk);
    while (busy) @(negedge clk);
    a = 8'h5A;
    b = 8'h5A;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, a_big, b_big, equal, steps} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run: got %b required 0", {busy, done, a_big, b_big, equal, steps});
    end
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: activity=%b required 0", saw_done);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [WIDTH-1:0] ta;
    logic [WIDTH-1:0] tb_v;
    logic tsm;
    logic [SW+2:0] exp;
    for (int n = 0; n < 150; n++) begin
      ta  = WIDTH'($urandom);
      tsm = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       tb_v = ta;
        1:       tb_v = ta ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: tb_v = WIDTH'($urandom);
      endcase
      exp = model(ta, tb_v, tsm);
      do_compare(ta, tb_v, tsm, lat);
      vectors++;
      if ({a_big, b_big, equal, steps} !== exp || lat !== int'(exp[SW-1:0])) begin
        miscompares++;
        $display("FAIL random a=%h b=%h s=%b: res=%b lat=%0d required res=%b lat=%0d", ta, tb_v, tsm,
                 {a_big, b_big, equal, steps}, lat, exp, int'(exp[SW-1:0]));
      end
    end
  endtask

`ifdef SERIAL_MAGNITUDE_COMPARATOR_STATS_EN
  task automatic test_stats();
    int lat;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) do_compare(8'hC3, 8'h13, 1'b0, lat);
    @(posedge clk);
    #1;
    vectors++;
    if ({cnt_a_big, cnt_b_big, cnt_equal} !== {2'd3, 2'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL stats_saturate: got a=%0d b=%0d e=%0d required 3 0 0", cnt_a_big, cnt_b_big, cnt_equal);
    end
    do_compare(8'h13, 8'hC3, 1'b0, lat);
    @(posedge clk);
    #1;
    vectors++;
    if (cnt_b_big !== 2'd1) begin
      miscompares++;
      $display("FAIL stats_b_count: got %0d required 1", cnt_b_big);
    end
    do_compare(8'h13, 8'hC3, 1'b0, lat);
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    vectors++;
    if ({cnt_a_big, cnt_b_big, cnt_equal} !== '0) begin
      miscompares++;
      $display("FAIL stats_clr_vs_done: got a=%0d b=%0d e=%0d required 0 0 0", cnt_a_big, cnt_b_big, cnt_equal);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_MAGNITUDE_COMPARATOR_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_early_exit();
    test_equal();
    test_signed();
    test_back_to_back();
    test_robust();
    test_random();
`ifdef SERIAL_MAGNITUDE_COMPARATOR_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
